// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and queued load results onto one register-bank write port.
// Optional queue-starvation protection is enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int unsigned NUMREGS      = 32,
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned FIFODEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           alu_valid_i,
  output logic                           alu_ready_o,
  input  logic [$clog2(NUMREGS)-1:0]     alu_addr_i,
  input  logic [DATAWIDTH-1:0]           alu_data_i,
  input  logic                           mem_valid_i,
  output logic                           mem_ready_o,
  input  logic [$clog2(NUMREGS)-1:0]     mem_addr_i,
  input  logic [DATAWIDTH-1:0]           mem_data_i,
  output logic                           we_o,
  output logic [$clog2(NUMREGS)-1:0]     waddr_o,
  output logic [DATAWIDTH-1:0]           wdata_o,
  output logic [$clog2(FIFODEPTH):0]     q_count_o
);

  localparam int unsigned AW = $clog2(NUMREGS);
  localparam int unsigned PW = $clog2(FIFODEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]        addr_mem_q [FIFODEPTH];
  logic [DATAWIDTH-1:0] data_mem_q [FIFODEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;

  logic q_nonempty;
  logic force_queue;
  logic alu_grant;
  logic q_grant;
  logic enq;

  assign q_nonempty  = (count_q != '0);
  assign mem_ready_o = (count_q != CW'(FIFODEPTH));
  // Acceptance ignores a same-cycle dequeue, so a full queue never accepts.
  assign enq         = mem_valid_i & mem_ready_o;
  assign alu_grant   = alu_valid_i & ~force_queue;
  assign q_grant     = ~alu_grant & q_nonempty;
  assign alu_ready_o = alu_grant;
  assign q_count_o   = count_q;

  always_comb begin
    we_o    = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    if (alu_grant) begin
      waddr_o = alu_addr_i;
      wdata_o = alu_data_i;
      we_o    = (alu_addr_i != '0);
    end else if (q_grant) begin
      waddr_o = addr_mem_q[rd_ptr_q];
      wdata_o = data_mem_q[rd_ptr_q];
      we_o    = (addr_mem_q[rd_ptr_q] != '0);
    end
  end

  always_comb begin
    count_d = count_q;
    if (enq && !q_grant) begin
      count_d = count_q + CW'(1);
    end else if (!enq && q_grant) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFODEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_mem_q[wr_ptr_q] <= mem_addr_i;
        data_mem_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (q_grant) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [SW-1:0] starve_q, starve_d;

  assign force_queue = q_nonempty && (starve_q == SW'(STARVE_LIMIT));

  // Counts ALU wins that bypassed a waiting load; any load grant or empty queue restarts it.
  always_comb begin
    starve_d = starve_q;
    if (q_grant || !q_nonempty) begin
      starve_d = '0;
    end else if (alu_grant) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;

  assign force_queue         = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_wb_arbiter;

  localparam int unsigned NR = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 4;
  localparam int unsigned SL = 3;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          alu_valid_i = 1'b0;
  logic          alu_ready_o;
  logic [4:0]    alu_addr_i = '0;
  logic [DW-1:0] alu_data_i = '0;
  logic          mem_valid_i = 1'b0;
  logic          mem_ready_o;
  logic [4:0]    mem_addr_i = '0;
  logic [DW-1:0] mem_data_i = '0;
  logic          we_o;
  logic [4:0]    waddr_o;
  logic [DW-1:0] wdata_o;
  logic [2:0]    q_count_o;

  wb_arbiter #(
    .NUMREGS     (NR),
    .DATAWIDTH   (DW),
    .FIFODEPTH   (FD),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alu_valid_i(alu_valid_i),
    .alu_ready_o(alu_ready_o),
    .alu_addr_i (alu_addr_i),
    .alu_data_i (alu_data_i),
    .mem_valid_i(mem_valid_i),
    .mem_ready_o(mem_ready_o),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .q_count_o  (q_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   starve = 0;
  int   tests  = 0;
  int   fails  = 0;
  int   alu_wins = 0;
  int   load_wins = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model, then advance.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [DW-1:0] md,
                       output bit acc);
    bit ag, qg, qn, frc;
    logic [4:0] ea;
    logic [DW-1:0] ed;
    ent_t e;
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
    mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md;
    #3;
    qn  = (mq.size() != 0);
    frc = GUARD && qn && (starve == SL);
    ag  = av && !frc;
    qg  = !ag && qn;
    ea  = '0;
    ed  = '0;
    if (ag) begin
      ea = aa; ed = ad;
    end else if (qg) begin
      ea = mq[0].a; ed = mq[0].d;
    end
    chk("alu_ready", alu_ready_o, ag);
    chk("mem_ready", mem_ready_o, mq.size() != FD);
    chk("q_count", q_count_o, mq.size());
    chk("we", we_o, (ag || qg) && (ea != 0));
    chk("waddr", waddr_o, ea);
    chk("wdata", wdata_o, ed);
    acc = mv && (mq.size() != FD);
    if (ag) alu_wins++;
    if (qg) begin
      load_wins++;
      void'(mq.pop_front());
    end
    if (acc) begin
      e.a = ma; e.d = md;
      mq.push_back(e);
    end
    if (GUARD) begin
      if (qg || !qn) starve = 0;
      else if (ag) starve++;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int idx;
    logic [4:0] ra, ma;

    // Reset state, alu_ready follows alu_valid even in reset.
    #12;
    chk("rst_we", we_o, 1'b0);
    chk("rst_qcount", q_count_o, 0);
    chk("rst_mem_ready", mem_ready_o, 1'b1);
    chk("rst_waddr", waddr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    alu_valid_i = 1'b1; alu_addr_i = 5'd0;
    #1;
    chk("rst_alu_ready", alu_ready_o, 1'b1);
    alu_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Single ALU write, zero latency.
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, acc);

    // Four back-to-back loads with the ALU idle, then drain.
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 1, 5'(i), 32'(i * 16), acc);
      chk("b2b_qcount_le1", q_count_o <= 1, 1'b1);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, acc);

    // ALU always valid while five loads are offered.
    idx = 0;
    load_wins = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, 5'(8 + (i % 4)), 32'h1000 + 32'(i), idx < 5, 5'(20 + idx), 32'hA0 + 32'(idx), acc);
      if (acc) idx++;
    end
    chk("starve_load_wins", load_wins > 0, GUARD);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0, acc);

    // Address 0 is consumed without a write from either source.
    cycle(1, 5'd0, 32'hFF, 1, 5'd0, 32'h55, acc);
    cycle(0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, acc);

    // Reset with three loads queued discards them.
    for (int i = 0; i < 3; i++) cycle(1, 5'd9, 32'h77, 1, 5'(i + 1), 32'hC0 + 32'(i), acc);
    chk("pre_rst_qcount", q_count_o, 3);
    alu_valid_i = 1'b0; mem_valid_i = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_qcount", q_count_o, 0);
    chk("mid_rst_we", we_o, 1'b0);
    mq.delete();
    starve = 0;
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, acc);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ra = 5'($urandom_range(0, 31));
      ma = 5'($urandom_range(0, 31));
      cycle($urandom_range(0, 99) < 55, ra, $urandom, $urandom_range(0, 99) < 45, ma, $urandom, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
